// File: rtl/mips_pkg.sv
// mips_pkg: shared EX-stage types and constants for the sequential multiplier.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration -- add/subtract M per {Q[0], q_1}, then arithmetic shift right.
module booth_step
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_1
);
  logic [WIDTH:0] w_sum;
  always_comb begin
    w_sum = ({i_q[0], i_q_1} == 2'b01) ? i_a + i_m :
            ({i_q[0], i_q_1} == 2'b10) ? i_a - i_m : i_a;
    o_a   = {w_sum[WIDTH], w_sum[WIDTH:1]};
    o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    o_q_1 = i_q[0];
  end
endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed radix-2 Booth multiplier, one step per clock.
module booth_multiplier
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           r_state, w_next;
  logic [WIDTH:0]   r_a, r_m, w_a;
  logic [WIDTH-1:0] r_q, w_q;
  logic             r_q_1, w_q_1;
  logic [CW-1:0]    r_count;
  logic [2*WIDTH-1:0] r_product;
  logic             w_accept, w_last;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_a   (r_a),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_a   (w_a),
    .o_q   (w_q),
    .o_q_1 (w_q_1)
  );

  // start is only honoured outside RUN, including the DONE cycle
  always_comb begin
    w_accept = start && (r_state != RUN);
    w_last   = (r_state == RUN) && (r_count == CW'(1));
    w_next   = w_accept ? RUN : (r_state == DONE) ? IDLE : w_last ? DONE : r_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_q       <= '0;
      r_q_1     <= 1'b0;
      r_m       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a     <= '0;
      r_q     <= multiplier;
      r_q_1   <= 1'b0;
      r_m     <= {multiplicand[WIDTH-1], multiplicand};
      r_count <= CW'(WIDTH);
    end else if (r_state == RUN) begin
      r_a     <= w_a;
      r_q     <= w_q;
      r_q_1   <= w_q_1;
      r_count <= r_count - CW'(1);
      if (w_last) r_product <= {w_a[WIDTH-1:0], w_q};
    end
  end

  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_product;
endmodule
